// File: rtl/x_window_ctrl.sv
// Sequencing controller for the x shift-register memory: fills a TAPS-sample
// window, fires one compute per window and slides by one sample between windows.
module x_window_ctrl #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 8,
  parameter int LEN   = 16,
  parameter int CNTW  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in,
  input  logic             s_valid_in,
  output logic             s_ready_out,
  output logic             x_wr_en,
  output logic [WIDTH-1:0] x_data_out,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             last_window,
  output logic [CNTW-1:0]  win_idx,
  output logic             vec_done
);

  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(LEN - TAPS);
  localparam logic [CNTW-1:0] FILL_TOP = CNTW'(TAPS - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SLIDE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CNTW-1:0] fill_cnt_r;
  logic [CNTW-1:0] fill_cnt_next_s;
  logic [CNTW-1:0] win_idx_r;
  logic [CNTW-1:0] win_idx_next_s;
  logic            accept_s;
  logic            last_s;

  assign x_data_out  = s_data_in;
  assign win_idx     = win_idx_r;
  assign last_window = last_s;

  // Next-state, counter updates and the reset-gated handshake/pulse outputs
  always_comb begin
    state_next_s    = state_r;
    fill_cnt_next_s = fill_cnt_r;
    win_idx_next_s  = win_idx_r;
    s_ready_out     = 1'b0;
    conv_start      = 1'b0;
    vec_done        = 1'b0;
    last_s          = (win_idx_r == LAST_IDX);
    accept_s        = 1'b0;

    case (state_r)
      FILL: begin
        s_ready_out = reset;
        accept_s    = s_valid_in & reset;
        if (accept_s) begin
          if (fill_cnt_r == FILL_TOP) begin
            fill_cnt_next_s = '0;
            state_next_s    = START;
          end else begin
            fill_cnt_next_s = fill_cnt_r + 1'b1;
          end
        end else begin
          fill_cnt_next_s = fill_cnt_r;
        end
      end
      START: begin
        conv_start   = reset;
        state_next_s = WAIT;
      end
      WAIT: begin
        if (conv_done) begin
          if (last_s) begin
            vec_done       = reset;
            win_idx_next_s = '0;
            state_next_s   = FILL;
          end else begin
            state_next_s   = SLIDE;
          end
        end else begin
          state_next_s = WAIT;
        end
      end
      SLIDE: begin
        s_ready_out = reset;
        accept_s    = s_valid_in & reset;
        if (accept_s) begin
          win_idx_next_s = win_idx_r + 1'b1;
          state_next_s   = START;
        end else begin
          state_next_s = SLIDE;
        end
      end
      default: begin
        state_next_s    = FILL;
        fill_cnt_next_s = '0;
        win_idx_next_s  = '0;
      end
    endcase

    x_wr_en = accept_s;
  end

  // State and counter registers; reset abandons any partial vector
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= FILL;
      fill_cnt_r <= '0;
      win_idx_r  <= '0;
    end else begin
      state_r    <= state_next_s;
      fill_cnt_r <= fill_cnt_next_s;
      win_idx_r  <= win_idx_next_s;
    end
  end

endmodule

// File: tb/tb_x_window_ctrl.sv
// Directed bench for x_window_ctrl: default-parameter instance plus a TAPS==LEN instance.
module tb_x_window_ctrl;

  localparam int WIDTH = 16;
  localparam int CNTW  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, s_valid_in, conv_done;
  logic [WIDTH-1:0] s_data_in;
  logic             s_ready_out, x_wr_en, conv_start, last_window, vec_done;
  logic [WIDTH-1:0] x_data_out;
  logic [CNTW-1:0]  win_idx;

  logic             r2, v2, dn2;
  logic [WIDTH-1:0] d2;
  logic             rdy2, wr2, st2, lw2, vd2;
  logic [WIDTH-1:0] xd2;
  logic [CNTW-1:0]  wi2;

  x_window_ctrl #(.WIDTH(16), .TAPS(8), .LEN(16), .CNTW(10)) dut (
    .clk(clk), .reset(reset), .s_data_in(s_data_in), .s_valid_in(s_valid_in),
    .s_ready_out(s_ready_out), .x_wr_en(x_wr_en), .x_data_out(x_data_out),
    .conv_start(conv_start), .conv_done(conv_done), .last_window(last_window),
    .win_idx(win_idx), .vec_done(vec_done)
  );

  x_window_ctrl #(.WIDTH(16), .TAPS(8), .LEN(8), .CNTW(10)) dut_single (
    .clk(clk), .reset(r2), .s_data_in(d2), .s_valid_in(v2),
    .s_ready_out(rdy2), .x_wr_en(wr2), .x_data_out(xd2),
    .conv_start(st2), .conv_done(dn2), .last_window(lw2),
    .win_idx(wi2), .vec_done(vd2)
  );

  int checks = 0;
  int fails  = 0;
  logic [WIDTH-1:0] exp_data_q[$];
  logic [CNTW:0]    exp_win_q[$];
  logic             exp_vec = 1'b0;
  int start_cnt = 0, vec_cnt = 0, wr_cnt = 0, last_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pops the expected sample / window whenever the DUT produces one
  task automatic monitor();
    logic [CNTW:0] w;
    if (x_wr_en === 1'b1) begin
      wr_cnt++;
      chk("write_expected", 32'(exp_data_q.size() > 0), 32'd1);
      if (exp_data_q.size() > 0) chk("x_data_out", 32'(x_data_out), 32'(exp_data_q.pop_front()));
    end
    if (conv_start === 1'b1) begin
      start_cnt++;
      chk("start_expected", 32'(exp_win_q.size() > 0), 32'd1);
      if (exp_win_q.size() > 0) begin
        w = exp_win_q.pop_front();
        chk("win_idx", 32'(win_idx), 32'(w[CNTW-1:0]));
        chk("last_window", 32'(last_window), 32'(w[CNTW]));
      end
    end
    if (vec_done === 1'b1) vec_cnt++;
    chk("vec_done", 32'(vec_done), 32'(exp_vec));
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    bit acc;
    int n;
    n = 0;
    exp_data_q.push_back(v);
    s_valid_in = 1'b1;
    s_data_in  = v;
    do begin
      @(negedge clk);
      acc = x_wr_en;
      monitor();
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 40);
    s_valid_in = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
    last_lat = n;
  endtask

  task automatic wait_start();
    bit s;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      s = conv_start;
      monitor();
      @(posedge clk);
      #1;
      n++;
    end while (!s && n < 10);
    chk("conv_start_seen", 32'(s), 32'd1);
    last_lat = n;
  endtask

  // Called in the first WAIT cycle; returns conv_done two cycles after conv_start
  task automatic finish_window(input bit last, input bit noise);
    cycle();
    conv_done = 1'b1;
    exp_vec   = last;
    @(negedge clk);
    chk("ready_in_wait", 32'(s_ready_out), 32'd0);
    monitor();
    @(posedge clk);
    #1;
    conv_done = noise;
    exp_vec   = 1'b0;
    @(negedge clk);
    chk("ready_after_done", 32'(s_ready_out), 32'd1);
    monitor();
    @(posedge clk);
    #1;
    conv_done = 1'b0;
  endtask

  task automatic run_vector(input bit noise);
    int sv, vv, wv;
    sv = start_cnt; vv = vec_cnt; wv = wr_cnt;
    for (int i = 1; i <= 8; i++) begin
      if (noise && i > 1) begin
        conv_done = 1'b1;
        cycle();
        conv_done = 1'b0;
      end
      if (i == 8) exp_win_q.push_back({1'b0, 10'd0});
      send(WIDTH'(i));
      if (!noise) chk("fill_back_to_back", 32'(last_lat), 32'd1);
    end
    wait_start();
    chk("fill_start_latency", 32'(last_lat), 32'd1);
    finish_window(1'b0, noise);
    for (int k = 1; k <= 8; k++) begin
      if (noise) cycle();
      exp_win_q.push_back({(k == 8), CNTW'(k)});
      send(WIDTH'(8 + k));
      wait_start();
      chk("slide_start_latency", 32'(last_lat), 32'd1);
      finish_window(k == 8, noise && k < 8);
    end
    chk("start_pulses", 32'(start_cnt - sv), 32'd9);
    chk("vec_pulses", 32'(vec_cnt - vv), 32'd1);
    chk("writes", 32'(wr_cnt - wv), 32'd16);
  endtask

  initial begin
    reset = 1'b0; s_valid_in = 1'b1; s_data_in = 16'h0005; conv_done = 1'b1;
    r2 = 1'b0; v2 = 1'b0; d2 = 16'h0000; dn2 = 1'b0;

    // Outputs gated while reset is low, even with valid and conv_done asserted
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(s_ready_out), 32'd0);
      chk("rst_wr_en", 32'(x_wr_en), 32'd0);
      chk("rst_start", 32'(conv_start), 32'd0);
      chk("rst_vec_done", 32'(vec_done), 32'd0);
      chk("rst_win_idx", 32'(win_idx), 32'd0);
      chk("rst_last_window", 32'(last_window), 32'd0);
      @(posedge clk);
      #1;
    end
    s_valid_in = 1'b0; conv_done = 1'b0; reset = 1'b1;

    run_vector(1'b0);
    run_vector(1'b1);

    // Reset while waiting on window 4
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_win_q.push_back({1'b0, 10'd0});
      send(WIDTH'(16'h0100 + i));
    end
    wait_start();
    finish_window(1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      exp_win_q.push_back({1'b0, CNTW'(k)});
      send(WIDTH'(16'h0200 + k));
      wait_start();
      if (k < 4) finish_window(1'b0, 1'b0);
    end
    chk("win_idx_before_reset", 32'(win_idx), 32'd4);
    reset = 1'b0; conv_done = 1'b1;
    @(negedge clk);
    chk("reset_wait_ready", 32'(s_ready_out), 32'd0);
    monitor();
    @(posedge clk);
    #1;
    reset = 1'b1; conv_done = 1'b0;
    @(negedge clk);
    chk("after_reset_win_idx", 32'(win_idx), 32'd0);
    chk("after_reset_ready", 32'(s_ready_out), 32'd1);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_win_q.push_back({1'b0, 10'd0});
      send(WIDTH'(16'h0300 + i));
    end
    wait_start();
    chk("refill_start_latency", 32'(last_lat), 32'd1);

    // Valid held high while in WAIT: nothing may be written
    s_valid_in = 1'b1; s_data_in = 16'hBEEF;
    repeat (20) begin
      @(negedge clk);
      chk("wait_hold_ready", 32'(s_ready_out), 32'd0);
      chk("wait_hold_wr_en", 32'(x_wr_en), 32'd0);
      monitor();
      @(posedge clk);
      #1;
    end
    s_valid_in = 1'b0;
    finish_window(1'b0, 1'b0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;

    // TAPS == LEN: one window per vector, returning straight to FILL
    r2 = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= 8; i++) begin
        v2 = 1'b1; d2 = WIDTH'(16'h0A00 + i);
        @(negedge clk);
        chk("single_wr_en", 32'(wr2), 32'd1);
        chk("single_data", 32'(xd2), 32'(16'h0A00 + i));
        chk("single_no_early_start", 32'(st2), 32'd0);
        @(posedge clk);
        #1;
      end
      v2 = 1'b0;
      @(negedge clk);
      chk("single_start", 32'(st2), 32'd1);
      chk("single_last_window", 32'(lw2), 32'd1);
      chk("single_win_idx", 32'(wi2), 32'd0);
      @(posedge clk);
      #1;
      dn2 = 1'b1;
      @(negedge clk);
      chk("single_vec_done", 32'(vd2), 32'd1);
      @(posedge clk);
      #1;
      dn2 = 1'b0;
      @(negedge clk);
      chk("single_ready_fill", 32'(rdy2), 32'd1);
      chk("single_no_vec_after", 32'(vd2), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
